// File: rtl/multi_timer.sv
// rtl/multi_timer.sv - N independent down-counting timers with tick, toggle and busy outputs
module multi_timer #(
  parameter int N_CH  = 3,
  parameter int CNT_W = 22
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [N_CH-1:0]       i_start,
  input  logic [N_CH-1:0]       i_stop,
  input  logic [N_CH-1:0]       i_oneshot,
  input  logic [N_CH*CNT_W-1:0] i_period,
  output logic [N_CH-1:0]       o_tick,
  output logic [N_CH-1:0]       o_toggle,
  output logic [N_CH-1:0]       o_busy,
  output logic [N_CH*CNT_W-1:0] o_count
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q [N_CH];
  state_t           state_d [N_CH];
  logic [CNT_W-1:0] cnt_q   [N_CH];
  logic [CNT_W-1:0] cnt_d   [N_CH];
  logic [CNT_W-1:0] per_q   [N_CH];
  logic [CNT_W-1:0] per_d   [N_CH];
  logic [N_CH-1:0]  mode_q, mode_d;
  logic [N_CH-1:0]  tick_q, tick_d;
  logic [N_CH-1:0]  tog_q, tog_d;

  // Reload value: a period of zero behaves like a period of one.
  function automatic logic [CNT_W-1:0] p_minus1(input logic [CNT_W-1:0] p);
    return (p == '0) ? '0 : (p - ONE);
  endfunction

  // Per-channel next state: stop beats start, start beats expiry.
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
      per_d[k]   = per_q[k];
      mode_d[k]  = mode_q[k];
      tog_d[k]   = tog_q[k];
      tick_d[k]  = 1'b0;
      if (i_stop[k]) begin
        state_d[k] = ST_IDLE;
      end else if (i_start[k]) begin
        per_d[k]   = i_period[k*CNT_W +: CNT_W];
        mode_d[k]  = i_oneshot[k];
        cnt_d[k]   = p_minus1(i_period[k*CNT_W +: CNT_W]);
        state_d[k] = ST_RUN;
      end else if (state_q[k] == ST_RUN) begin
        if (cnt_q[k] == '0) begin
          tick_d[k] = 1'b1;
          tog_d[k]  = ~tog_q[k];
          if (mode_q[k]) begin
            state_d[k] = ST_IDLE;
          end else begin
            cnt_d[k] = p_minus1(per_q[k]);
          end
        end else begin
          cnt_d[k] = cnt_q[k] - ONE;
        end
      end
    end
  end

  // State registers with synchronous reset that dominates all strobes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < N_CH; k++) begin
        state_q[k] <= ST_IDLE;
        cnt_q[k]   <= '0;
        per_q[k]   <= '0;
      end
      mode_q <= '0;
      tick_q <= '0;
      tog_q  <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
        per_q[k]   <= per_d[k];
      end
      mode_q <= mode_d;
      tick_q <= tick_d;
      tog_q  <= tog_d;
    end
  end

  // Pack per-channel registers onto the output buses.
  always_comb begin
    o_count = '0;
    o_busy  = '0;
    for (int k = 0; k < N_CH; k++) begin
      o_count[k*CNT_W +: CNT_W] = cnt_q[k];
      o_busy[k]                 = (state_q[k] == ST_RUN);
    end
  end

  assign o_tick   = tick_q;
  assign o_toggle = tog_q;

endmodule

// File: tb/tb_multi_timer.sv
// tb/tb_multi_timer.sv - directed vector and sequence checks for multi_timer
module tb_multi_timer;

  localparam int NC = 3;
  localparam int CW = 22;

  logic             clk = 1'b0;
  logic             rst;
  logic [NC-1:0]    start, stop, oneshot;
  logic [NC*CW-1:0] period;
  logic [NC-1:0]    tick, toggle, busy;
  logic [NC*CW-1:0] count;

  int checks = 0;
  int errors = 0;

  multi_timer #(.N_CH(NC), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop),
    .i_oneshot(oneshot), .i_period(period), .o_tick(tick),
    .o_toggle(toggle), .o_busy(busy), .o_count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic [2:0]    start;
    logic [2:0]    stop;
    logic [2:0]    oneshot;
    logic [CW-1:0] p0, p1, p2;
    logic [2:0]    e_tick;
    logic [2:0]    e_tog;
    logic [2:0]    e_busy;
    int            ch;
    logic [CW-1:0] e_cnt;
  } vec_t;

  localparam int NV = 24;
  vec_t vec [NV];

  function automatic vec_t row(input logic r, input logic [2:0] st, input logic [2:0] sp,
                               input logic [2:0] os, input int p0, input int p1, input int p2,
                               input logic [2:0] et, input logic [2:0] eg, input logic [2:0] eb,
                               input int ch, input int ec);
    vec_t v;
    v.rst = r; v.start = st; v.stop = sp; v.oneshot = os;
    v.p0 = p0[CW-1:0]; v.p1 = p1[CW-1:0]; v.p2 = p2[CW-1:0];
    v.e_tick = et; v.e_tog = eg; v.e_busy = eb; v.ch = ch; v.e_cnt = ec[CW-1:0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] cnt_of(input int k);
    return count[k*CW +: CW];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = '0; stop = '0; oneshot = '0;
    step();
    rst = 1'b0;
  endtask

  int ntick [NC];
  int nbad  [NC];
  int sp    [NC];

  initial begin
    rst = 1'b1; start = '0; stop = '0; oneshot = '0; period = '0;

    //             rst start  stop   os     p0 p1 p2  tick   tog    busy   ch cnt
    vec[0]  = row(1, 3'b000, 3'b000, 3'b000, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0, 0);
    vec[1]  = row(0, 3'b010, 3'b000, 3'b010, 0, 3, 0, 3'b000, 3'b000, 3'b010, 1, 2);
    vec[2]  = row(0, 3'b000, 3'b000, 3'b000, 0, 7, 0, 3'b000, 3'b000, 3'b010, 1, 1);
    vec[3]  = row(0, 3'b000, 3'b000, 3'b000, 0, 7, 0, 3'b000, 3'b000, 3'b010, 1, 0);
    vec[4]  = row(0, 3'b000, 3'b000, 3'b000, 0, 7, 0, 3'b010, 3'b010, 3'b000, 1, 0);
    vec[5]  = row(0, 3'b000, 3'b000, 3'b000, 0, 0, 0, 3'b000, 3'b010, 3'b000, 1, 0);
    vec[6]  = row(0, 3'b001, 3'b001, 3'b000, 5, 0, 0, 3'b000, 3'b010, 3'b000, 0, 0);
    vec[7]  = row(0, 3'b100, 3'b000, 3'b000, 0, 0, 0, 3'b000, 3'b010, 3'b100, 2, 0);
    vec[8]  = row(0, 3'b000, 3'b000, 3'b000, 0, 0, 0, 3'b100, 3'b110, 3'b100, 2, 0);
    vec[9]  = row(0, 3'b000, 3'b000, 3'b000, 0, 0, 0, 3'b100, 3'b010, 3'b100, 2, 0);
    vec[10] = row(0, 3'b000, 3'b100, 3'b000, 0, 0, 0, 3'b000, 3'b010, 3'b000, 2, 0);
    vec[11] = row(0, 3'b000, 3'b010, 3'b000, 0, 0, 0, 3'b000, 3'b010, 3'b000, 1, 0);
    vec[12] = row(0, 3'b001, 3'b000, 3'b000, 4, 0, 0, 3'b000, 3'b010, 3'b001, 0, 3);
    vec[13] = row(0, 3'b000, 3'b000, 3'b000, 4, 0, 0, 3'b000, 3'b010, 3'b001, 0, 2);
    vec[14] = row(0, 3'b000, 3'b001, 3'b000, 4, 0, 0, 3'b000, 3'b010, 3'b000, 0, 2);
    vec[15] = row(0, 3'b000, 3'b000, 3'b000, 4, 0, 0, 3'b000, 3'b010, 3'b000, 0, 2);
    vec[16] = row(0, 3'b001, 3'b000, 3'b000, 2, 0, 0, 3'b000, 3'b010, 3'b001, 0, 1);
    vec[17] = row(0, 3'b000, 3'b000, 3'b000, 2, 0, 0, 3'b000, 3'b010, 3'b001, 0, 0);
    vec[18] = row(0, 3'b001, 3'b000, 3'b000, 2, 0, 0, 3'b000, 3'b010, 3'b001, 0, 1);
    vec[19] = row(0, 3'b000, 3'b000, 3'b000, 2, 0, 0, 3'b000, 3'b010, 3'b001, 0, 0);
    vec[20] = row(0, 3'b000, 3'b000, 3'b000, 2, 0, 0, 3'b001, 3'b011, 3'b001, 0, 1);
    vec[21] = row(1, 3'b001, 3'b000, 3'b000, 2, 0, 0, 3'b000, 3'b000, 3'b000, 0, 0);
    vec[22] = row(0, 3'b001, 3'b000, 3'b000, 3, 0, 0, 3'b000, 3'b000, 3'b001, 0, 2);
    vec[23] = row(1, 3'b000, 3'b000, 3'b000, 3, 0, 0, 3'b000, 3'b000, 3'b000, 0, 0);

    for (int i = 0; i < NV; i++) begin
      rst = vec[i].rst; start = vec[i].start; stop = vec[i].stop;
      oneshot = vec[i].oneshot; period = {vec[i].p2, vec[i].p1, vec[i].p0};
      step();
      chk($sformatf("vec%0d_tick", i), {29'd0, tick}, {29'd0, vec[i].e_tick});
      chk($sformatf("vec%0d_toggle", i), {29'd0, toggle}, {29'd0, vec[i].e_tog});
      chk($sformatf("vec%0d_busy", i), {29'd0, busy}, {29'd0, vec[i].e_busy});
      chk($sformatf("vec%0d_count", i), {10'd0, cnt_of(vec[i].ch)}, {10'd0, vec[i].e_cnt});
    end

    // ch0 periodic P=10: ticks every 10 cycles, count runs 9..0
    do_reset();
    start = 3'b001; period = '0; period[CW-1:0] = 22'd10;
    step();
    start = '0;
    chk("p10_busy", {31'd0, busy[0]}, 32'd1);
    chk("p10_cnt0", {10'd0, cnt_of(0)}, 32'd9);
    for (int c = 1; c <= 30; c++) begin
      step();
      chk($sformatf("p10_tick_c%0d", c), {31'd0, tick[0]}, (c % 10 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("p10_tog_c%0d", c), {31'd0, toggle[0]}, ((c / 10) % 2 == 1) ? 32'd1 : 32'd0);
      chk($sformatf("p10_cnt_c%0d", c), {10'd0, cnt_of(0)}, 32'(9 - (c % 10)));
    end
    stop = 3'b001;
    step();
    stop = '0;
    chk("p10_stop_busy", {31'd0, busy[0]}, 32'd0);

    // ch1 one-shot P=3: one tick, then silent and idle
    do_reset();
    start = 3'b010; oneshot = 3'b010; period = '0; period[CW +: CW] = 22'd3;
    step();
    start = '0; oneshot = '0;
    for (int c = 1; c <= 23; c++) begin
      step();
      chk($sformatf("os_tick_c%0d", c), {31'd0, tick[1]}, (c == 3) ? 32'd1 : 32'd0);
      if (c >= 3) chk($sformatf("os_busy_c%0d", c), {31'd0, busy[1]}, 32'd0);
    end

    // ch2 P=1 periodic: tick every cycle, toggle every cycle, then stop
    do_reset();
    start = 3'b100; period = '0; period[2*CW +: CW] = 22'd1;
    step();
    start = '0;
    for (int c = 1; c <= 5; c++) begin
      step();
      chk($sformatf("p1_tick_c%0d", c), {31'd0, tick[2]}, 32'd1);
      chk($sformatf("p1_tog_c%0d", c), {31'd0, toggle[2]}, 32'(c % 2));
    end
    stop = 3'b100;
    step();
    stop = '0;
    chk("p1_stop_tick", {31'd0, tick[2]}, 32'd0);
    chk("p1_stop_busy", {31'd0, busy[2]}, 32'd0);
    chk("p1_stop_tog", {31'd0, toggle[2]}, 32'd1);

    // ch0 P=8 restarted with P=5 while count is 2
    do_reset();
    start = 3'b001; period = '0; period[CW-1:0] = 22'd8;
    step();
    start = '0;
    for (int c = 1; c <= 5; c++) step();
    chk("rs_cnt_before", {10'd0, cnt_of(0)}, 32'd2);
    start = 3'b001; period[CW-1:0] = 22'd5;
    step();
    start = '0;
    chk("rs_cnt_after", {10'd0, cnt_of(0)}, 32'd4);
    for (int r = 1; r <= 7; r++) begin
      step();
      chk($sformatf("rs_tick_r%0d", r), {31'd0, tick[0]}, (r == 5) ? 32'd1 : 32'd0);
    end

    // Long periods: all channels load and count down without ticking
    do_reset();
    start = 3'b111;
    period = {22'd2800000, 22'd300000, 22'd1000000};
    step();
    start = '0;
    for (int k = 0; k < NC; k++) ntick[k] = 0;
    for (int c = 1; c <= 1000; c++) begin
      step();
      for (int k = 0; k < NC; k++) if (tick[k]) ntick[k]++;
    end
    chk("long_cnt0", {10'd0, cnt_of(0)}, 32'd998999);
    chk("long_cnt1", {10'd0, cnt_of(1)}, 32'd298999);
    chk("long_cnt2", {10'd0, cnt_of(2)}, 32'd2798999);
    chk("long_ticks", 32'(ntick[0] + ntick[1] + ntick[2]), 32'd0);
    chk("long_busy", {29'd0, busy}, 32'd7);

    // Same period ratios at 1/1000: ticks land on exact multiples
    do_reset();
    sp[0] = 1000; sp[1] = 300; sp[2] = 2800;
    start = 3'b111;
    period = {22'd2800, 22'd300, 22'd1000};
    step();
    start = '0;
    for (int k = 0; k < NC; k++) begin ntick[k] = 0; nbad[k] = 0; end
    for (int c = 1; c <= 5600; c++) begin
      step();
      for (int k = 0; k < NC; k++) begin
        if (tick[k]) ntick[k]++;
        if (tick[k] !== ((c % sp[k]) == 0)) nbad[k]++;
      end
    end
    for (int k = 0; k < NC; k++) begin
      chk($sformatf("multi_misplaced_ch%0d", k), 32'(nbad[k]), 32'd0);
      chk($sformatf("multi_count_ch%0d", k), 32'(ntick[k]), 32'(5600 / sp[k]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_timer.md
MULTI_TIMER -- requirements
Module: multi_timer

Interface
REQ-001 The block SHALL have parameter N_CH, default 3: number of independent timer channels (1..16).
REQ-002 The block SHALL have parameter CNT_W, default 22: period/counter width per channel (fits 2.8 s at 1 MHz).
REQ-003 The block SHALL have port i_clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 The block SHALL have port i_rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port i_start, input, N_CH bits: per-channel one-cycle start/restart strobe.
REQ-006 The block SHALL have port i_stop, input, N_CH bits: per-channel one-cycle stop strobe.
REQ-007 The block SHALL have port i_oneshot, input, N_CH bits: mode, sampled at start (0 periodic, 1 one-shot).
REQ-008 The block SHALL have port i_period, input, N_CH*CNT_W bits: per-channel period P in cycles; channel k uses bits [k*CNT_W +: CNT_W]; sampled at start.
REQ-009 The block SHALL have port o_tick, output, N_CH bits: one-cycle pulse per expiry.
REQ-010 The block SHALL have port o_toggle, output, N_CH bits: level inverted on every tick (square wave, period 2P in periodic mode).
REQ-011 The block SHALL have port o_busy, output, N_CH bits: channel is in RUN.
REQ-012 The block SHALL have port o_count, output, N_CH*CNT_W bits: current down-counter value per channel, same packing as i_period.

Function
REQ-013 Each channel SHALL implement a two-state FSM: IDLE and RUN; channels SHALL be fully independent.
REQ-014 On i_start[k] in any state, channel k SHALL latch P and mode, load counter with P-1 (P=0 treated as P=1), and enter RUN in the next cycle.
REQ-015 In RUN, counter SHALL decrement by 1 each cycle; on the cycle the counter equals 0, o_tick[k] SHALL be asserted in the following cycle (registered) and o_toggle[k] SHALL invert on that same cycle.
REQ-016 First tick SHALL occur exactly P cycles after the start strobe cycle; subsequent periodic ticks SHALL be exactly P cycles apart.
REQ-017 Periodic mode: at counter 0 the counter SHALL reload latched P-1 with no idle cycle; channel stays in RUN.
REQ-018 One-shot mode: at counter 0 the channel SHALL emit one tick, enter IDLE, and hold counter at 0.
REQ-019 On i_stop[k] the channel SHALL enter IDLE next cycle, freeze the counter, emit no tick that cycle even if counter is 0, and keep o_toggle unchanged.
REQ-020 Simultaneous i_start[k] and i_stop[k]: stop SHALL win.
REQ-021 i_start[k] in RUN SHALL restart from the new P-1 and suppress any tick due that cycle.
REQ-022 Changes to i_period or i_oneshot while in RUN SHALL have no effect until the next start.
REQ-023 i_stop in IDLE and strobes held high for multiple cycles SHALL be treated as repeated strobes (level-sensitive per cycle).
REQ-024 o_busy[k] SHALL be 1 exactly while the FSM is in RUN.
REQ-025 P=1 periodic SHALL produce o_tick high every cycle and o_toggle toggling every cycle.
REQ-026 Counter arithmetic SHALL be unsigned CNT_W bits; maximum P = 2^CNT_W-1; no wrap below 0.

Reset
REQ-027 With i_rst high at a rising edge, all channels SHALL enter IDLE, with o_tick=0, o_toggle=0, o_busy=0, o_count=0, latched P=0, and mode=periodic.
REQ-028 i_rst SHALL dominate i_start and i_stop; reset mid-RUN SHALL abort without a tick.
REQ-029 The first cycle after reset deassertion SHALL accept i_start.

Verification
REQ-030 Bench SHALL cover: reset, then start ch0 with P=10 periodic -> o_tick[0] at cycles 10, 20, 30 after start; o_toggle[0] toggles at each; o_count follows 9..0.
REQ-031 Bench SHALL cover: ch1 with P=3, one-shot -> single tick 3 cycles after start, then o_busy[1]=0 and no further ticks for 20 cycles.
REQ-032 Bench SHALL cover: ch2 with P=1 periodic -> o_tick[2]=1 every cycle; stop -> o_tick[2]=0 next cycle and o_busy[2]=0.
REQ-033 Bench SHALL cover: ch0 with P=8, restart at count 2 with P=5 -> next tick 5 cycles after restart and no tick at the old expiry.
REQ-034 Bench SHALL cover: start and stop on the same cycle -> channel remains IDLE; reset asserted mid-RUN -> all outputs 0 next cycle, no tick.
REQ-035 Bench SHALL cover: all channels started together with P=1000000, 300000, and 2800000 at a 1 MHz i_clk -> ticks at 1.0 s, 0.3 s, and 2.8 s multiples.
